// File: rtl/pc_fetch_redirect_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_redirect_if
// Description : Bundle of the redirect, instruction-memory and fetch-output
//               signals around the PC/fetch redirect unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_redirect_if;
    // Hazard and redirect inputs from decode / branch resolution
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_base;
    logic [31:0] redirect_imm;
    logic        redirect_jalr;

    // Instruction memory handshake
    logic        imem_ack;
    logic        imem_req;
    logic [31:0] imem_addr;

    // Fetch results and pipeline control
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        flush;
    logic        misalign_trap;
    logic [31:0] trap_pc;

    // Fetch unit side
    modport master (
        input  stall, redirect_valid, redirect_base, redirect_imm, redirect_jalr,
        input  imem_ack,
        output imem_req, imem_addr,
        output fetch_valid, fetch_pc, flush, misalign_trap, trap_pc
    );

    // Surrounding pipeline / memory side
    modport slave (
        output stall, redirect_valid, redirect_base, redirect_imm, redirect_jalr,
        output imem_ack,
        input  imem_req, imem_addr,
        input  fetch_valid, fetch_pc, flush, misalign_trap, trap_pc
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_redirect.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_redirect
// Description : Program counter and fetch sequencer. Issues sequential
//               fetches, takes branch/jump redirects with a fixed-length
//               flush window, and traps on word-misaligned redirect targets.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_redirect #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pc_fetch_redirect_if.master   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_TRAP  = 2'd3
    } state_t;

    // Flush window length; legal values 1..7 fit in the 3-bit counter
    localparam logic [2:0] C_FLUSH_INIT = 3'(FLUSH_CYCLES);

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_fetch_valid;
    logic [31:0] r_fetch_pc;
    logic [2:0]  r_flush_cnt;
    logic        r_trap;
    logic [31:0] r_trap_pc;

    logic [31:0] w_sum;
    logic [31:0] w_target;
    logic        w_misaligned;

    // Redirect target: base + imm, with bit 0 cleared for jalr before the
    // alignment check so an odd rs1 can still yield a legal jalr target.
    assign w_sum        = bus.redirect_base + bus.redirect_imm;
    assign w_target     = {w_sum[31:1], w_sum[0] & ~bus.redirect_jalr};
    assign w_misaligned = (w_target[1:0] != 2'b00);

    // Fetch state machine, PC, fetch result and trap capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_fetch_pc    <= 32'h0000_0000;
            r_flush_cnt   <= 3'd0;
            r_trap        <= 1'b0;
            r_trap_pc     <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_fetch_valid <= 1'b0;
                    r_state       <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.redirect_valid) begin
                        // Redirect outranks stall and any memory acceptance
                        r_fetch_valid <= 1'b0;
                        if (w_misaligned) begin
                            r_state   <= ST_TRAP;
                            r_trap    <= 1'b1;
                            r_trap_pc <= w_target;
                        end else begin
                            r_pc        <= w_target;
                            r_state     <= ST_FLUSH;
                            r_flush_cnt <= C_FLUSH_INIT;
                        end
                    end else if (bus.stall) begin
                        r_fetch_valid <= 1'b0;
                    end else if (bus.imem_ack) begin
                        r_fetch_valid <= 1'b1;
                        r_fetch_pc    <= r_pc;
                        r_pc          <= r_pc + 32'd4;
                    end else begin
                        r_fetch_valid <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    // PC already holds the target; just count the window out
                    r_fetch_valid <= 1'b0;
                    r_flush_cnt   <= r_flush_cnt - 3'd1;
                    if (r_flush_cnt == 3'd1) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_TRAP: begin
                    // Terminal until reset
                    r_fetch_valid <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req      = (r_state == ST_RUN) & ~bus.stall;
    assign bus.imem_addr     = r_pc;
    assign bus.fetch_valid   = r_fetch_valid;
    assign bus.fetch_pc      = r_fetch_pc;
    assign bus.flush         = (r_state == ST_FLUSH) | (r_state == ST_TRAP);
    assign bus.misalign_trap = r_trap;
    assign bus.trap_pc       = r_trap_pc;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_redirect.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_redirect
// Description : Directed self-checking bench for pc_fetch_redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pc_fetch_redirect;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    pc_fetch_redirect_if bus ();

    pc_fetch_redirect #(
        .RESET_PC     (32'h0000_0000),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_redirect(input logic v, input logic [31:0] base,
                                input logic [31:0] imm, input logic jalr);
        bus.redirect_valid = v;
        bus.redirect_base  = base;
        bus.redirect_imm   = imm;
        bus.redirect_jalr  = jalr;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_total++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", bus.imem_req); else n_pass++;
        n_total++; if (bus.imem_addr !== 32'h0) $display("FAIL rst_addr got %h exp 00000000", bus.imem_addr); else n_pass++;
        n_total++; if (bus.fetch_valid !== 1'b0) $display("FAIL rst_fv got %b exp 0", bus.fetch_valid); else n_pass++;
        n_total++; if (bus.flush !== 1'b0) $display("FAIL rst_flush got %b exp 0", bus.flush); else n_pass++;
        n_total++; if (bus.misalign_trap !== 1'b0 || bus.trap_pc !== 32'h0) $display("FAIL rst_trap got %b/%h exp 0/00000000", bus.misalign_trap, bus.trap_pc); else n_pass++;
    endtask

    task automatic test_sequential();
        rst_n = 1'b1;
        #1;
        n_total++; if (bus.imem_req !== 1'b0) $display("FAIL idle_req got %b exp 0", bus.imem_req); else n_pass++;
        tick();
        n_total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) $display("FAIL run0 got req %b addr %h exp 1 00000000", bus.imem_req, bus.imem_addr); else n_pass++;
        n_total++; if (bus.fetch_valid !== 1'b0) $display("FAIL run0_fv got %b exp 0", bus.fetch_valid); else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_total++; if (bus.imem_addr !== 32'(4 * i)) $display("FAIL seq_addr%0d got %h exp %h", i, bus.imem_addr, 32'(4 * i)); else n_pass++;
            n_total++; if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 32'(4 * (i - 1))) $display("FAIL seq_fetch%0d got %b %h exp 1 %h", i, bus.fetch_valid, bus.fetch_pc, 32'(4 * (i - 1))); else n_pass++;
        end
    endtask

    // PC is 0x10 on entry
    task automatic test_redirect();
        set_redirect(1'b1, 32'h0000_0010, 32'hFFFF_FFF0, 1'b0);
        tick();
        set_redirect(1'b0, 32'h0, 32'h0, 1'b0);
        n_total++; if (bus.flush !== 1'b1 || bus.imem_req !== 1'b0 || bus.fetch_valid !== 1'b0) $display("FAIL redir_f1 got flush %b req %b fv %b exp 1 0 0", bus.flush, bus.imem_req, bus.fetch_valid); else n_pass++;
        n_total++; if (bus.imem_addr !== 32'h0) $display("FAIL redir_pc got %h exp 00000000", bus.imem_addr); else n_pass++;
        tick();
        n_total++; if (bus.flush !== 1'b1 || bus.imem_req !== 1'b0) $display("FAIL redir_f2 got flush %b req %b exp 1 0", bus.flush, bus.imem_req); else n_pass++;
        tick();
        n_total++; if (bus.flush !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) $display("FAIL redir_run got flush %b req %b addr %h exp 0 1 00000000", bus.flush, bus.imem_req, bus.imem_addr); else n_pass++;
    endtask

    task automatic test_redirect_stall();
        bus.stall = 1'b1;
        set_redirect(1'b1, 32'h0000_0101, 32'h0000_0004, 1'b1);
        #1;
        n_total++; if (bus.imem_req !== 1'b0) $display("FAIL stall_req got %b exp 0", bus.imem_req); else n_pass++;
        tick();
        bus.stall = 1'b0;
        set_redirect(1'b0, 32'h0, 32'h0, 1'b0);
        n_total++; if (bus.flush !== 1'b1 || bus.misalign_trap !== 1'b0 || bus.imem_addr !== 32'h104) $display("FAIL jalr_redir got flush %b trap %b addr %h exp 1 0 00000104", bus.flush, bus.misalign_trap, bus.imem_addr); else n_pass++;
        tick();
        tick();
        n_total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h104 || bus.flush !== 1'b0) $display("FAIL jalr_run got req %b addr %h flush %b exp 1 00000104 0", bus.imem_req, bus.imem_addr, bus.flush); else n_pass++;
    endtask

    task automatic test_wrap_stall();
        set_redirect(1'b1, 32'hFFFF_FFF0, 32'h0000_000C, 1'b0);
        tick();
        set_redirect(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        n_total++; if (bus.imem_addr !== 32'hFFFF_FFFC || bus.imem_req !== 1'b1) $display("FAIL wrap_pre got addr %h req %b exp fffffffc 1", bus.imem_addr, bus.imem_req); else n_pass++;
        tick();
        n_total++; if (bus.imem_addr !== 32'h0 || bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 32'hFFFF_FFFC) $display("FAIL wrap got addr %h fv %b fpc %h exp 00000000 1 fffffffc", bus.imem_addr, bus.fetch_valid, bus.fetch_pc); else n_pass++;
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (bus.imem_addr !== 32'h0 || bus.fetch_valid !== 1'b0 || bus.imem_req !== 1'b0) $display("FAIL stall%0d got addr %h fv %b req %b exp 00000000 0 0", i, bus.imem_addr, bus.fetch_valid, bus.imem_req); else n_pass++;
        end
        bus.stall = 1'b0;
        tick();
        n_total++; if (bus.imem_addr !== 32'h4 || bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 32'h0) $display("FAIL unstall got addr %h fv %b fpc %h exp 00000004 1 00000000", bus.imem_addr, bus.fetch_valid, bus.fetch_pc); else n_pass++;
        tick();
    endtask

    // PC is 8, last fetch_pc is 4 on entry
    task automatic test_flush_reset();
        set_redirect(1'b1, 32'h0000_0200, 32'h0000_0040, 1'b0);
        tick();
        set_redirect(1'b1, 32'h0000_0300, 32'h0000_0000, 1'b0);
        tick();
        set_redirect(1'b0, 32'h0, 32'h0, 1'b0);
        n_total++; if (bus.flush !== 1'b1 || bus.imem_addr !== 32'h240 || bus.fetch_pc !== 32'h4) $display("FAIL flush_ign got flush %b addr %h fpc %h exp 1 00000240 00000004", bus.flush, bus.imem_addr, bus.fetch_pc); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.flush !== 1'b0 || bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b0 || bus.fetch_valid !== 1'b0 || bus.fetch_pc !== 32'h0) $display("FAIL async_rst got flush %b addr %h req %b fv %b fpc %h exp 0 0 0 0 0", bus.flush, bus.imem_addr, bus.imem_req, bus.fetch_valid, bus.fetch_pc); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) $display("FAIL rerun got req %b addr %h exp 1 00000000", bus.imem_req, bus.imem_addr); else n_pass++;
    endtask

    task automatic test_misalign();
        tick();
        set_redirect(1'b1, 32'h0000_0100, 32'h0000_0002, 1'b0);
        tick();
        set_redirect(1'b1, 32'h0000_0400, 32'h0000_0000, 1'b0);
        n_total++; if (bus.misalign_trap !== 1'b1 || bus.trap_pc !== 32'h102) $display("FAIL trap got %b pc %h exp 1 00000102", bus.misalign_trap, bus.trap_pc); else n_pass++;
        n_total++; if (bus.imem_req !== 1'b0 || bus.flush !== 1'b1 || bus.imem_addr !== 32'h4) $display("FAIL trap_out got req %b flush %b addr %h exp 0 1 00000004", bus.imem_req, bus.flush, bus.imem_addr); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (bus.imem_req !== 1'b0 || bus.misalign_trap !== 1'b1 || bus.imem_addr !== 32'h4 || bus.trap_pc !== 32'h102) $display("FAIL trap_hold%0d got req %b trap %b addr %h tpc %h exp 0 1 00000004 00000102", i, bus.imem_req, bus.misalign_trap, bus.imem_addr, bus.trap_pc); else n_pass++;
        end
        set_redirect(1'b0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.misalign_trap !== 1'b0 || bus.trap_pc !== 32'h0 || bus.flush !== 1'b0) $display("FAIL trap_clr got %b %h %b exp 0 00000000 0", bus.misalign_trap, bus.trap_pc, bus.flush); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) $display("FAIL trap_rerun got req %b addr %h exp 1 00000000", bus.imem_req, bus.imem_addr); else n_pass++;
    endtask

    // jalr clears bit 0 only; bit 1 set still traps
    task automatic test_jalr_misalign();
        set_redirect(1'b1, 32'h0000_0203, 32'h0000_0000, 1'b1);
        tick();
        set_redirect(1'b0, 32'h0, 32'h0, 1'b0);
        n_total++; if (bus.misalign_trap !== 1'b1 || bus.trap_pc !== 32'h202) $display("FAIL jalr_trap got %b pc %h exp 1 00000202", bus.misalign_trap, bus.trap_pc); else n_pass++;
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        rst_n         = 1'b0;
        bus.stall     = 1'b0;
        bus.imem_ack  = 1'b1;
        set_redirect(1'b0, 32'h0, 32'h0, 1'b0);
        test_reset();
        test_sequential();
        test_redirect();
        test_redirect_stall();
        test_wrap_stall();
        test_flush_reset();
        test_misalign();
        test_jalr_misalign();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
